// File: rtl/uart_rx_mmio_if.sv
// CPU load-side bus of the memory-mapped UART receiver: load strobe, address,
// combinational read data and the receive interrupt.
interface uart_rx_mmio_if;
  logic       rd_en;
  logic [7:0] Address;
  logic [7:0] RegData;
  logic       rx_irq;

  modport master (
    output rd_en,
    output Address,
    input  RegData,
    input  rx_irq
  );

  modport slave (
    input  rd_en,
    input  Address,
    output RegData,
    output rx_irq
  );
endinterface

// File: rtl/uart_rx_mmio.sv
// Memory-mapped UART receiver: 8N1 deserialiser feeding a small byte FIFO read by CPU loads.
// Define UART_RX_PARITY_EN to receive 8E1 frames with an even-parity check (parity_err in STAT bit 3).
module uart_rx_mmio #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  ADDR_DATA  = 8'hFE,
  parameter logic [7:0]  ADDR_STAT  = 8'hFD
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rxd,
  uart_rx_mmio_if.slave  bus
);

  localparam int unsigned DIV  = CLK_HZ / BAUD;
  localparam int unsigned CW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned NW   = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] BAUD_HALF = CW'(DIV / 2);
  localparam logic [CW-1:0] BAUD_FULL = CW'(DIV - 1);
  localparam logic [NW-1:0] DEPTH_N   = NW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  logic          sync1_q, sync2_q, prev_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [NW-1:0] count_q, count_d;
  logic          irq_q;
  logic          frame_err_q, overrun_q, parity_err_q;

  logic tick, empty, full, pop, stat_rd;
  logic push, set_fe, set_ovr, set_pe;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
`endif

  assign tick    = (baud_q == '0);
  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_N);
  assign pop     = bus.rd_en && (bus.Address == ADDR_DATA) && !empty;
  assign stat_rd = bus.rd_en && (bus.Address == ADDR_STAT);

  // Receive FSM: operates only on the synchronised line (sync2_q) and its delayed copy.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
    set_fe  = 1'b0;
    set_ovr = 1'b0;
    set_pe  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = S_START;
          baud_d  = BAUD_HALF;
        end
      end
      S_START: begin
        if (!tick) begin
          baud_d = baud_q - CW'(1);
        end else if (!sync2_q) begin
          state_d = S_DATA;
          baud_d  = BAUD_FULL;
          bit_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (!tick) begin
          baud_d = baud_q - CW'(1);
        end else begin
          shift_d = {sync2_q, shift_q[7:1]};
          baud_d  = BAUD_FULL;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (!tick) begin
          baud_d = baud_q - CW'(1);
        end else begin
          par_bad_d = (^shift_q) ^ sync2_q;
          baud_d    = BAUD_FULL;
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (!tick) begin
          baud_d = baud_q - CW'(1);
        end else begin
          state_d = S_IDLE;
          if (!sync2_q) begin
            set_fe = 1'b1;
`ifdef UART_RX_PARITY_EN
            set_pe = par_bad_q;
          end else if (par_bad_q) begin
            set_pe = 1'b1;
`endif
          end else if (!full || pop) begin
            // A pop on the same edge frees a slot, so a full FIFO still accepts the byte.
            push = 1'b1;
          end else begin
            set_ovr = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + NW'(1);
      2'b01:   count_d = count_q - NW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      state_q      <= S_IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      count_q      <= '0;
      irq_q        <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
`endif
    end else begin
      sync1_q      <= rxd;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      count_q      <= count_d;
      irq_q        <= (count_d != '0);
      // Set has priority over the read-to-clear of a STAT load in the same cycle.
      frame_err_q  <= set_fe  | (frame_err_q  & ~stat_rd);
      overrun_q    <= set_ovr | (overrun_q    & ~stat_rd);
      parity_err_q <= set_pe  | (parity_err_q & ~stat_rd);
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= shift_q;
  end

  always_comb begin
    bus.RegData = '0;
    if (bus.Address == ADDR_DATA) begin
      bus.RegData = empty ? 8'h00 : mem_q[rd_q];
    end else if (bus.Address == ADDR_STAT) begin
      bus.RegData = {3'b000, full, parity_err_q, overrun_q, frame_err_q, !empty};
    end
  end

  assign bus.rx_irq = irq_q;

endmodule
